instruction_fetch_controller: RTL and testbench
===============================================

// Module: instruction_fetch_controller
// PURPOSE
//  Sequences fetches from the 128-bit-line instruction memory on behalf of the CPU front end.
//  Holds the last fetched line in a tagged line buffer and serves 32-bit words from it on a hit.
//  On a miss, requests the full line from memory, waits for it and then delivers the word.
//  Sits between the PC/fetch stage and the instruction memory.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles FILL waits for mem_valid before aborting with fetch_error
//  CNT_W           16  width of saturating miss_count
// PORTS
//  clock        in   1    single clock; all logic on posedge
//  reset        in   1    synchronous, active-high
//  cpu_req      in   1    fetch request; transfer when cpu_req && cpu_ready
//  cpu_addr     in   32   byte address; [31:4] line tag, [3:2] word select, [1:0] ignored
//  cpu_ready    out  1    controller can accept a request this cycle
//  inst_valid   out  1    one-cycle pulse: instruction is valid
//  instruction  out  32   fetched word; held until next inst_valid
//  flush        in   1    invalidate line buffer(s), cancel pending delivery
//  mem_req      out  1    line request to memory; held high until mem_valid
//  mem_addr     out  32   {tag,4'b0}; stable while mem_req=1
//  mem_valid    in   1    one-cycle pulse: mem_line valid
//  mem_line     in   128  line data; byte 0 in [7:0], word k in [32k+31:32k]
//  fetch_error  out  1    one-cycle pulse on memory timeout
//  miss_count   out  CNT_W  demand misses since reset, saturating at all-ones
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits 0, tags 0, cpu_ready=0 in reset cycle then 1,
//   inst_valid=0, instruction=0, mem_req=0, mem_addr=0, fetch_error=0, miss_count=0.
//  States: IDLE, FILL, DRAIN (one cycle, flush-abort wait), PREFETCH (option only).
//  IDLE: cpu_ready = !flush. Accepted request: latch addr.
//   hit (valid && tag==addr[31:4]) -> inst_valid=1 next cycle with word addr[3:2]; stay IDLE.
//    Back-to-back hits give one instruction per cycle.
//   miss -> next cycle FILL, mem_req=1, mem_addr={addr[31:4],4'b0}, miss_count+1 (saturating).
//  FILL: cpu_ready=0; timeout counter counts from 0.
//   mem_valid -> capture line, set tag and valid, drop mem_req;
//    next cycle inst_valid=1 with latched word; IDLE.
//   Counter reaches TIMEOUT_CYCLES with no mem_valid -> fetch_error pulse, mem_req=0,
//    buffer left invalid, no inst_valid; IDLE.
//   mem_valid outside FILL/PREFETCH is ignored.
//  flush: clears valid bit(s) the same edge.
//   In FILL it sets a drop flag; the fill continues to mem_valid or timeout,
//    the line is discarded and no inst_valid is issued.
//   flush with cpu_req in IDLE: flush wins; request not accepted.
//  Reset mid-FILL: abandons the request immediately (mem_req=0 next cycle).
//   A late mem_valid is ignored.
//  Line-boundary: address 0xFFFF_FFF0 hits/misses normally; tags do not wrap.
// CONFIGURATION
//  IFC_PREFETCH_EN defined: second buffer (next-line).
//   After a demand fill with no error or drop, if line tag+1 (mod 2^28) is not already
//    buffered, enter PREFETCH: mem_req for {tag+1,4'b0}, cpu_ready=0 until mem_valid.
//    Prefetch misses are not counted in miss_count.
//   Hit checks both buffers; a prefetch-buffer hit swaps it into the demand slot.
//   Timeout in PREFETCH: no fetch_error; buffer left invalid.
//  IFC_PREFETCH_EN undefined: single buffer; PREFETCH state and logic absent;
//   IDLE after every fill.
// TESTING
//  1 reset, cpu_req addr 0x40, mem_valid after 4 cycles with line bytes i
//     -> mem_addr=0x40, inst_valid with 0x43424140, miss_count=1.
//  2 after test 1, requests 0x44,0x48,0x4C back-to-back
//     -> 3 consecutive inst_valid: 0x47464544, 0x4B4A4948, 0x4F4E4D4C; mem_req stays 0.
//  3 miss on 0x80, flush asserted in FILL, mem_valid later
//     -> no inst_valid; re-request of 0x80 misses again, miss_count+1.
//  4 miss on 0x100, mem_valid never arrives
//     -> fetch_error pulse at TIMEOUT_CYCLES; cpu_ready=1 next cycle.
//  5 reset asserted mid-FILL -> next cycle all outputs at reset values; late mem_valid ignored.
//  6 IFC_PREFETCH_EN: fill 0x40 -> PREFETCH issues mem_addr=0x50;
//     then request 0x54 -> hit, inst_valid with 0x57565554, no new mem_req.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Fetch controller with a tagged line buffer: a hit gives the word 1 cycle after accept, a miss gives it 1 cycle after mem_valid.
// cpu_ready is low while a fill is outstanding or flush is high. IFC_PREFETCH_EN adds a next-line prefetch buffer.
module instruction_fetch_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    output logic              cpu_ready,
    output logic              inst_valid,
    output logic [31:0]       instruction,
    input  logic              flush,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_valid,
    input  logic [127:0]      mem_line,
    output logic              fetch_error,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef IFC_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DRAIN = 2'd2, S_PREFETCH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DRAIN = 2'd2} state_t;
`endif

    state_t         state, state_nxt;
    logic           d_valid;
    logic [27:0]    d_tag;
    logic [127:0]   d_line;
    logic [1:0]     word_sel;
    logic           drop;
    logic [TW-1:0]  tmo_cnt;

    logic           accept, d_hit, hit, timeout;
    logic [27:0]    req_tag;
    logic           unused_addr_bits;

`ifdef IFC_PREFETCH_EN
    logic           pf_valid;
    logic [27:0]    pf_tag;
    logic [127:0]   pf_line;
    logic           pf_hit, need_pf;
    logic [27:0]    next_tag;
`endif

    function automatic logic [31:0] pick(input logic [127:0] line, input logic [1:0] sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

    assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};
    assign req_tag = cpu_addr[31:4];
    assign accept  = cpu_req && cpu_ready;
    assign d_hit   = d_valid && (d_tag == req_tag);
    assign timeout = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) && !mem_valid;

`ifdef IFC_PREFETCH_EN
    assign pf_hit   = pf_valid && (pf_tag == req_tag);
    assign hit      = d_hit || pf_hit;
    // Tag arithmetic wraps mod 2^28, so the line after 0xFFFF_FFF0 is line 0.
    assign next_tag = mem_addr[31:4] + 28'd1;
    assign need_pf  = !(pf_valid && (pf_tag == next_tag));
`else
    assign hit      = d_hit;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && !hit) state_nxt = S_FILL;
            S_FILL: begin
                if (mem_valid || timeout) begin
                    if (drop || flush) state_nxt = S_DRAIN;
`ifdef IFC_PREFETCH_EN
                    else if (mem_valid && need_pf) state_nxt = S_PREFETCH;
`endif
                    else state_nxt = S_IDLE;
                end
            end
            S_DRAIN: state_nxt = S_IDLE;
`ifdef IFC_PREFETCH_EN
            S_PREFETCH: if (mem_valid || timeout) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        case (state)
            S_IDLE: cpu_ready = !reset && !flush;
            S_FILL: mem_req = 1'b1;
`ifdef IFC_PREFETCH_EN
            S_PREFETCH: mem_req = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid     <= 1'b0;
            d_tag       <= '0;
            d_line      <= '0;
            word_sel    <= '0;
            drop        <= 1'b0;
            tmo_cnt     <= '0;
            inst_valid  <= 1'b0;
            instruction <= '0;
            mem_addr    <= '0;
            fetch_error <= 1'b0;
            miss_count  <= '0;
`ifdef IFC_PREFETCH_EN
            pf_valid    <= 1'b0;
            pf_tag      <= '0;
            pf_line     <= '0;
`endif
        end else begin
            inst_valid  <= 1'b0;
            fetch_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        word_sel <= cpu_addr[3:2];
                        if (d_hit) begin
                            inst_valid  <= 1'b1;
                            instruction <= pick(d_line, cpu_addr[3:2]);
`ifdef IFC_PREFETCH_EN
                        end else if (pf_hit) begin
                            inst_valid  <= 1'b1;
                            instruction <= pick(pf_line, cpu_addr[3:2]);
                            d_valid     <= pf_valid;
                            d_tag       <= pf_tag;
                            d_line      <= pf_line;
                            pf_valid    <= d_valid;
                            pf_tag      <= d_tag;
                            pf_line     <= d_line;
`endif
                        end else begin
                            mem_addr <= {req_tag, 4'b0000};
                            tmo_cnt  <= '0;
                            drop     <= 1'b0;
                            if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (flush) drop <= 1'b1;
                    if (mem_valid) begin
                        if (!(drop || flush)) begin
                            d_line      <= mem_line;
                            d_tag       <= mem_addr[31:4];
                            d_valid     <= 1'b1;
                            inst_valid  <= 1'b1;
                            instruction <= pick(mem_line, word_sel);
`ifdef IFC_PREFETCH_EN
                            if (need_pf) begin
                                mem_addr <= {next_tag, 4'b0000};
                                tmo_cnt  <= '0;
                                pf_valid <= 1'b0;
                            end
`endif
                        end
                    end else if (timeout) begin
                        fetch_error <= 1'b1;
                    end
                end
`ifdef IFC_PREFETCH_EN
                S_PREFETCH: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (flush) drop <= 1'b1;
                    if (mem_valid && !(drop || flush)) begin
                        pf_line  <= mem_line;
                        pf_tag   <= mem_addr[31:4];
                        pf_valid <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
            // Flush invalidates every buffer regardless of what the state logic did this edge.
            if (flush) begin
                d_valid <= 1'b0;
`ifdef IFC_PREFETCH_EN
                pf_valid <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller; covers the prefetch path when IFC_PREFETCH_EN is defined.
module tb_instruction_fetch_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         cpu_ready;
    logic         inst_valid;
    logic [31:0]  instruction;
    logic         flush;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic [127:0] mem_line;
    logic         fetch_error;
    logic [15:0]  miss_count;

    int checks = 0;
    int errors = 0;

    instruction_fetch_controller #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .inst_valid(inst_valid), .instruction(instruction),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_line(mem_line), .fetch_error(fetch_error), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        mem_valid = 1'b0; mem_line = '0;

        // Reset values
        tick(); tick(); at_neg();
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_instruction", instruction, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fetch_error", fetch_error, 0);
        check("rst_miss_count", miss_count, 0);
        tick(); reset = 1'b0;
        at_neg();
        check("idle_cpu_ready", cpu_ready, 1);

        // Test 1: miss on 0x40, line arrives 4 cycles later
        cpu_req = 1'b1; cpu_addr = 32'h40;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_cpu_ready_fill", cpu_ready, 0);
        check("t1_miss_count", miss_count, 1);
        repeat (3) tick();
        mem_valid = 1'b1; mem_line = mk_line(8'h40);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("t1_inst_valid", inst_valid, 1);
        check("t1_instruction", instruction, 32'h43424140);
`ifdef IFC_PREFETCH_EN
        check("t6_pf_mem_req", mem_req, 1);
        check("t6_pf_mem_addr", mem_addr, 32'h50);
        check("t6_pf_cpu_ready", cpu_ready, 0);
`else
        check("t1_mem_req_drop", mem_req, 0);
`endif
        tick(); at_neg();
        check("t1_inst_valid_pulse", inst_valid, 0);
        check("t1_instruction_held", instruction, 32'h43424140);
`ifdef IFC_PREFETCH_EN
        mem_valid = 1'b1; mem_line = mk_line(8'h50);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("t6_pf_done_mem_req", mem_req, 0);
        check("t6_pf_done_ready", cpu_ready, 1);
        check("t6_pf_no_inst", inst_valid, 0);
        cpu_req = 1'b1; cpu_addr = 32'h54;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("t6_hit_valid", inst_valid, 1);
        check("t6_hit_instruction", instruction, 32'h57565554);
        check("t6_hit_mem_req", mem_req, 0);
        check("t6_pf_not_counted", miss_count, 1);
`endif

        // Test 2: back-to-back hits in line 0x40
        cpu_req = 1'b1; cpu_addr = 32'h44;
        tick(); cpu_addr = 32'h48;
        at_neg();
        check("t2_v0", inst_valid, 1);
        check("t2_w0", instruction, 32'h47464544);
        check("t2_mreq0", mem_req, 0);
        tick(); cpu_addr = 32'h4C;
        at_neg();
        check("t2_v1", inst_valid, 1);
        check("t2_w1", instruction, 32'h4B4A4948);
        check("t2_mreq1", mem_req, 0);
        tick(); cpu_req = 1'b0;
        at_neg();
        check("t2_v2", inst_valid, 1);
        check("t2_w2", instruction, 32'h4F4E4D4C);
        check("t2_mreq2", mem_req, 0);
        check("t2_miss_count", miss_count, 1);

        // Stray mem_valid while idle is ignored
        mem_valid = 1'b1; mem_line = mk_line(8'hA0);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("stray_inst_valid", inst_valid, 0);
        check("stray_mem_req", mem_req, 0);

        // Test 3: flush during fill drops the line
        cpu_req = 1'b1; cpu_addr = 32'h80;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("t3_mem_addr", mem_addr, 32'h80);
        check("t3_miss_count", miss_count, 2);
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        tick(); mem_valid = 1'b1; mem_line = mk_line(8'h80);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("t3_dropped_no_inst", inst_valid, 0);
        check("t3_drain_mem_req", mem_req, 0);
        check("t3_drain_not_ready", cpu_ready, 0);
        tick(); at_neg();
        check("t3_ready_after_drain", cpu_ready, 1);
        check("t3_still_no_inst", inst_valid, 0);
        // flush beats a simultaneous request
        flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h80;
        #1;
        check("t3_flush_blocks_ready", cpu_ready, 0);
        tick(); flush = 1'b0; cpu_req = 1'b0;
        at_neg();
        check("t3_flush_no_req", mem_req, 0);
        check("t3_flush_no_count", miss_count, 2);
        cpu_req = 1'b1; cpu_addr = 32'h80;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("t3_rereq_miss", mem_req, 1);
        check("t3_rereq_count", miss_count, 3);
        mem_valid = 1'b1; mem_line = mk_line(8'h80);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("t3_refill_valid", inst_valid, 1);
        check("t3_refill_word", instruction, 32'h83828180);
`ifdef IFC_PREFETCH_EN
        check("t3_pf_addr", mem_addr, 32'h90);
        mem_valid = 1'b1; mem_line = mk_line(8'h90);
        tick(); mem_valid = 1'b0;
        at_neg();
`endif

        // Test 4: memory never answers
        cpu_req = 1'b1; cpu_addr = 32'h100;
        tick(); cpu_req = 1'b0;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            at_neg();
            if (fetch_error) begin
                seen = 1'b1;
                break;
            end
            if (mem_req) n++;
            tick();
        end
        check("t4_error_seen", seen, 1);
        check("t4_wait_cycles", n, 64);
        check("t4_err_mem_req", mem_req, 0);
        check("t4_err_no_inst", inst_valid, 0);
        check("t4_miss_count", miss_count, 4);
        tick(); at_neg();
        check("t4_error_pulse", fetch_error, 0);
        check("t4_ready_after", cpu_ready, 1);

        // Test 5: reset mid-fill; buffer was left invalid so 0x100 misses again
        cpu_req = 1'b1; cpu_addr = 32'h100;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("t5_rereq_miss", mem_req, 1);
        check("t5_miss_count", miss_count, 5);
        tick(); tick(); reset = 1'b1;
        tick(); at_neg();
        check("t5_rst_mem_req", mem_req, 0);
        check("t5_rst_mem_addr", mem_addr, 0);
        check("t5_rst_ready", cpu_ready, 0);
        check("t5_rst_instruction", instruction, 0);
        check("t5_rst_miss_count", miss_count, 0);
        reset = 1'b0; mem_valid = 1'b1; mem_line = mk_line(8'h00);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("t5_late_no_inst", inst_valid, 0);
        check("t5_late_mem_req", mem_req, 0);
        check("t5_late_ready", cpu_ready, 1);

        // Top line of the address space
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_FFFC;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("top_mem_addr", mem_addr, 32'hFFFF_FFF0);
        check("top_miss_count", miss_count, 1);
        mem_valid = 1'b1; mem_line = mk_line(8'hF0);
        tick(); mem_valid = 1'b0;
        at_neg();
        check("top_valid", inst_valid, 1);
        check("top_word3", instruction, 32'hFFFEFDFC);
`ifdef IFC_PREFETCH_EN
        check("top_pf_wrap_addr", mem_addr, 32'h0);
        mem_valid = 1'b1; mem_line = mk_line(8'h00);
        tick(); mem_valid = 1'b0;
        at_neg();
`endif
        cpu_req = 1'b1; cpu_addr = 32'hFFFF_FFF0;
        tick(); cpu_req = 1'b0;
        at_neg();
        check("top_hit_valid", inst_valid, 1);
        check("top_hit_word0", instruction, 32'hF3F2F1F0);
        check("top_hit_mem_req", mem_req, 0);
        check("top_hit_count", miss_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
